// File: rtl/aqua_actuator_sequencer.sv
// Aquaculture actuator sequencer: commits a filtered water-condition level, drops
// actuators at once and staggers their turn-on, and generates the periodic feeder pulse.
module aqua_actuator_sequencer #(
   parameter int STAGGER_CYC = 4,
   parameter int MIN_DWELL   = 8,
   parameter int FEED_PERIOD = 64,
   parameter int FEED_PULSE  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_level,
   output logic       o_pump,
   output logic       o_aerator,
   output logic       o_valve,
   output logic       o_heater,
   output logic       o_uv,
   output logic       o_feeder,
   output logic [1:0] o_state,
   output logic       o_busy
);

   localparam logic [1:0] LVL_NORMAL   = 2'b00;
   localparam logic [1:0] LVL_WARNING  = 2'b01;
   localparam logic [1:0] LVL_CRITICAL = 2'b10;

   // Actuator vectors are ordered {pump, aerator, valve, heater, uv}; bit 4 has top priority.
   localparam logic [4:0] PAT_NORMAL   = 5'b11000;
   localparam logic [4:0] PAT_WARNING  = 5'b11011;
   localparam logic [4:0] PAT_CRITICAL = 5'b11101;

   localparam int DW_W = $clog2(MIN_DWELL + 1);
   localparam int ST_W = $clog2(STAGGER_CYC + 1);
   localparam int FC_W = $clog2(FEED_PERIOD);

   localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MIN_DWELL);
   localparam logic [ST_W-1:0] STAG_LAST = ST_W'(STAGGER_CYC - 1);
   localparam logic [FC_W-1:0] FEED_LAST = FC_W'(FEED_PERIOD - 1);
   localparam logic [FC_W-1:0] FEED_ON   = FC_W'(FEED_PERIOD - FEED_PULSE);

   logic [1:0]      r_lvl;
   logic [1:0]      r_state;
   logic [DW_W-1:0] r_dwell;
   logic [4:0]      r_act;
   logic [4:0]      r_pending;
   logic            r_busy;
   logic [ST_W-1:0] r_stag;
   logic [FC_W-1:0] r_feed;

   logic [1:0]      w_lvl_in;
   logic [4:0]      w_pat;
   logic [4:0]      w_next_bit;
   logic [4:0]      w_pend_after;
   logic            w_commit;

   assign w_lvl_in = (i_level == 2'b11) ? LVL_CRITICAL : i_level;

   always_comb begin
      w_pat = PAT_NORMAL;
      case (r_lvl)
         LVL_WARNING:  w_pat = PAT_WARNING;
         LVL_CRITICAL: w_pat = PAT_CRITICAL;
         default:      w_pat = PAT_NORMAL;
      endcase
   end

   // Critical escalation bypasses both the dwell hold-off and an in-flight sequence.
   assign w_commit = (r_lvl != r_state) &&
                     ((r_lvl == LVL_CRITICAL) || ((r_dwell == DWELL_MAX) && !r_busy));

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_pick
         assign w_next_bit[gi] = r_pending[gi] && ((r_pending >> (gi + 1)) == 5'd0);
      end
   endgenerate

   assign w_pend_after = r_pending & ~w_next_bit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lvl <= LVL_NORMAL;
      end else begin
         r_lvl <= w_lvl_in;
      end
   end

   // Reset behaves as a commit to NORMAL, so power-up runs the normal stagger.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= LVL_NORMAL;
         r_dwell   <= '0;
         r_act     <= '0;
         r_pending <= PAT_NORMAL;
         r_busy    <= 1'b1;
         r_stag    <= '0;
      end else if (w_commit) begin
         r_state   <= r_lvl;
         r_dwell   <= '0;
         r_act     <= r_act & w_pat;
         r_pending <= w_pat & ~r_act;
         r_busy    <= ((w_pat & ~r_act) != 5'd0);
         r_stag    <= '0;
      end else begin
         if (r_dwell != DWELL_MAX) begin
            r_dwell <= r_dwell + DW_W'(1);
         end
         if (r_busy) begin
            if (r_stag == STAG_LAST) begin
               r_act     <= r_act | w_next_bit;
               r_pending <= w_pend_after;
               r_busy    <= (w_pend_after != 5'd0);
               r_stag    <= '0;
            end else begin
               r_stag <= r_stag + ST_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_feed <= '0;
      end else if ((r_state == LVL_CRITICAL) || (r_feed == FEED_LAST)) begin
         r_feed <= '0;
      end else begin
         r_feed <= r_feed + FC_W'(1);
      end
   end

   assign o_pump    = r_act[4];
   assign o_aerator = r_act[3];
   assign o_valve   = r_act[2];
   assign o_heater  = r_act[1];
   assign o_uv      = r_act[0];
   assign o_state   = r_state;
   assign o_busy    = r_busy;
   // Masked straight from the state register so the pulse dies the cycle critical commits.
   assign o_feeder  = (r_state != LVL_CRITICAL) && (r_feed >= FEED_ON);

endmodule

// File: tb/tb_aqua_actuator_sequencer.sv
// Randomized bench for aqua_actuator_sequencer against a time-scheduled model:
// each commit books the turn-on time of every pending actuator.
module tb_aqua_actuator_sequencer;

   localparam int STAG  = 4;
   localparam int DWELL = 8;
   localparam int FP    = 64;
   localparam int FW    = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] level = 2'b00;
   logic       pump, aerator, valve, heater, uv, feeder, busy;
   logic [1:0] state;

   aqua_actuator_sequencer #(
      .STAGGER_CYC(STAG), .MIN_DWELL(DWELL), .FEED_PERIOD(FP), .FEED_PULSE(FW)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_level(level),
      .o_pump(pump), .o_aerator(aerator), .o_valve(valve), .o_heater(heater),
      .o_uv(uv), .o_feeder(feeder), .o_state(state), .o_busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: cycle index since reset release, last commit cycle, and a due cycle per actuator.
   int         t;
   int         last_c;
   int         due[5];
   logic [4:0] m_act;
   logic [1:0] m_st;
   logic [1:0] m_lq;
   int         m_feed;

   function automatic logic [4:0] pattern(input logic [1:0] l);
      if (l == 2'd1) return 5'b11011;
      if (l == 2'd2) return 5'b11101;
      return 5'b11000;
   endfunction

   function automatic bit m_busy();
      for (int b = 0; b < 5; b++) if (due[b] >= 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic schedule(input logic [4:0] pat);
      int k = 0;
      for (int b = 4; b >= 0; b--) begin
         if (pat[b] && !m_act[b]) begin
            k++;
            due[b] = t + k * STAG;
         end else begin
            due[b] = -1;
         end
      end
   endtask

   task automatic model_reset();
      t = 0; last_c = 0; m_act = '0; m_st = 2'd0; m_lq = 2'd0; m_feed = 0;
      schedule(pattern(2'd0));
   endtask

   task automatic model_edge();
      bit         commit;
      logic [1:0] old_st;
      t++;
      old_st = m_st;
      commit = (m_lq != m_st) && ((m_lq == 2'd2) || (((t - 1 - last_c) >= DWELL) && !m_busy()));
      if (commit) begin
         m_act  = m_act & pattern(m_lq);
         m_st   = m_lq;
         last_c = t;
         schedule(pattern(m_st));
      end else begin
         for (int b = 0; b < 5; b++) begin
            if (due[b] == t) begin
               m_act[b] = 1'b1;
               due[b]   = -1;
            end
         end
      end
      m_feed = (old_st == 2'd2) ? 0 : (m_feed + 1) % FP;
      m_lq   = (level == 2'd3) ? 2'd2 : level;
   endtask

   task automatic compare_all();
      chk("actuators", {3'b0, pump, aerator, valve, heater, uv}, {3'b0, m_act});
      chk("state", {6'b0, state}, {6'b0, m_st});
      chk("busy", {7'b0, busy}, {7'b0, m_busy()});
      chk("feeder", {7'b0, feeder}, {7'b0, (m_st != 2'd2) && (m_feed >= FP - FW)});
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         compare_all();
      end
   endtask

   // Reset takes effect between edges; outputs are checked before any edge occurs.
   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_actuators", {3'b0, pump, aerator, valve, heater, uv}, 8'd0);
      chk("rst_state", {6'b0, state}, 8'd0);
      chk("rst_busy", {7'b0, busy}, 8'd1);
      chk("rst_feeder", {7'b0, feeder}, 8'd0);
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int r;
      level = 2'd0;
      pulse_reset();
      run_cycles(140);

      level = 2'd1; run_cycles(2);
      level = 2'd2; run_cycles(2);
      level = 2'd0; run_cycles(24);
      level = 2'd3; run_cycles(15);
      level = 2'd0; run_cycles(30);
      level = 2'd1; run_cycles(4);
      pulse_reset();
      level = 2'd0; run_cycles(12);

      for (int seg = 0; seg < 40; seg++) begin
         r = $urandom_range(0, 9);
         if (r < 5)      level = 2'd0;
         else if (r < 8) level = 2'd1;
         else if (r < 9) level = 2'd2;
         else            level = 2'd3;
         run_cycles($urandom_range(1, 25));
         if ($urandom_range(0, 9) == 0) begin
            pulse_reset();
            run_cycles($urandom_range(1, 10));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aqua_actuator_sequencer.md
# aqua_actuator_sequencer

- Sequences the aquaculture plant actuators (pump, aerator, valve, heater, UV, feeder) from a 2-bit water-condition level.
- Enforces a minimum dwell time between condition changes and staggers actuator turn-on to limit inrush current.
- Generates the periodic feeder pulse, suppressed during critical conditions.
- Sits between the sensor/level logic and the actuator drivers; it is the sequencing controller for the condition FSM outputs.

## Interface
Parameters:
- STAGGER_CYC, 4: cycles between successive actuator turn-ons (≥1).
- MIN_DWELL, 8: cycles a committed level must be held before a non-critical change (≥1).
- FEED_PERIOD, 64: feeder period in cycles.
- FEED_PULSE, 4: feeder high time in cycles (< FEED_PERIOD).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- level  in  2  condition: 00 normal, 01 warning, 10 critical, 11 treated as critical.
- pump, aerator, valve, heater, uv  out  1 each  actuator enables (registered).
- feeder  out  1  feeder enable.
- state  out  2  committed level (00/01/10; 11 never driven).
- busy  out  1  turn-on sequencing in progress.

## Operation
- Target patterns, in order {pump, aerator, valve, heater, uv}:
  - NORMAL: 1,1,0,0,0.
  - WARNING: 1,1,0,1,1.
  - CRITICAL: 1,1,1,0,1.
- Input sampling: `level` is registered into lvl_q every edge; 11 maps to 10. All decisions use lvl_q.
- Dwell counter: cleared on commit, increments each edge, saturates at MIN_DWELL.
- Commit condition at an edge: lvl_q != state AND (lvl_q == CRITICAL OR (dwell == MIN_DWELL AND !busy)).
  - Escalation to critical preempts a sequence in progress and ignores dwell.
- On a commit edge:
  - `state` takes the new level.
  - Every actuator currently 1 that is 0 in the new pattern drops to 0 on that same edge.
  - Pending set = new pattern & ~current outputs.
  - Stagger count restarts.
- Turn-on: pending bits assert one at a time in priority order pump, aerator, valve, heater, uv. The k-th pending bit asserts at commit edge + k·STAGGER_CYC.
- busy:
  - Set on a commit edge with a non-empty pending set.
  - Clears on the edge where the last pending bit asserts.
  - A commit with an empty pending set leaves busy at 0.
- Feeder:
  - feed_cnt counts 0..FEED_PERIOD-1 and wraps.
  - feed_cnt is held at 0 on every edge where state == CRITICAL.
  - feeder = (state != CRITICAL) && (feed_cnt ≥ FEED_PERIOD−FEED_PULSE).
- Reset (asynchronous, takes effect immediately):
  - Actuators, feeder = 0; state = 00; dwell = 0; feed_cnt = 0; lvl_q = 00.
  - busy = 1, with pending = NORMAL pattern. Reset acts as a commit to NORMAL, with deassertion as edge 0.
  - Reset mid-sequence aborts the sequence and restarts the power-up sequence.

## Timing
- Level-to-commit latency: 2 edges. The input is captured at edge N and commits at edge N+1 if the commit condition holds.
- Turn-off latency: an actuator drops on the commit edge.
- Simultaneous events:
  - A commit on the same edge a pending bit was due: the commit wins; that bit asserts only if it is still pending under the new pattern.
  - A critical commit on the same edge busy would clear: busy follows the new pending set.
- Non-critical level changes are held off (no commit) while busy or while dwell < MIN_DWELL. The change commits on the first edge where both conditions are met, provided lvl_q still differs from state.
- Feeder edges are registered via feed_cnt. feeder masks to 0 in the same cycle that state becomes CRITICAL.

## Test plan
Defaults STAGGER_CYC=4, MIN_DWELL=8, FEED_PERIOD=64, FEED_PULSE=4.
- Power-up, level=00:
  - pump=1 after edge 4; aerator=1 after edge 8; busy 1→0 at edge 8; state=00.
  - feeder high after edges 60–63, low after edge 64, and repeats every 64 cycles.
- Settled NORMAL, level→01 before edge N:
  - commit at N+1, state=01.
  - heater=1 at N+5, uv=1 at N+9, busy low from N+9.
  - pump and aerator stay 1 throughout.
- In WARNING, level→10 two edges after a warning commit (heater still pending):
  - critical commits immediately; state=10; feeder=0.
  - valve at commit+4, uv at commit+8; heater never asserts.
- In CRITICAL, level→00 two edges after the critical commit:
  - no commit until dwell=8 and busy=0.
  - At that commit, valve and uv drop on the same edge; state=00; feeder resumes from feed_cnt=0.
- level=11:
  - behaves exactly as 10; state reads 10, never 11.
- rst_n pulsed low while a sequence is in progress:
  - all outputs 0 and busy=1 asynchronously, without waiting for an edge.
  - The power-up sequence repeats exactly as in scenario 1.
